spi_slave_wr_bridge: RTL and testbench

- Synthesizable SPI/QPI slave responder: the device-side end of the single/quad SPI load link that the host bench drives as SPI master.
- Oversamples the SPI pins in the core clock domain and decodes command/address/data frames.
- Converts burst-write frames into 32-bit bus write requests through a small FIFO with valid/ready handshake.
- Provides a mode/status register (quad enable, overflow) readable and writable over SPI.

---
 rtl/spi_slave_wr_bridge.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_spi_slave_wr_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_wr_bridge.sv
// ============================================================================
// Module   : spi_slave_wr_bridge
// Purpose  : SPI/QPI slave responder. Oversamples the SPI pins in the clk
//            domain, decodes command/address/data frames and turns burst
//            writes into 32-bit bus write requests through a small FIFO.
//            A mode/status register (quad enable, sticky overflow) is
//            readable (cmd 0x05) and writable (cmd 0x01) over SPI.
// Ports    : clk, rst            - core clock, synchronous active-high reset
//            spi_sck/csn/sdi     - SPI pins from the master (mode 0)
//            spi_sdo, spi_oe     - SPI data out and per-lane output enable
//            quad_mode, overflow - status register bits
//            wr_valid/wr_ready   - write request handshake
//            wr_addr, wr_data    - head-of-FIFO write request
// Options  : SPI_WORD_CNT_EN - adds a saturating 16-bit count of pushed
//            words, read by cmd 0x07, cleared by reg0 bit2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_wr_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_csn,
    input  logic [3:0]        spi_sdi,
    output logic [3:0]        spi_sdo,
    output logic [3:0]        spi_oe,
    output logic              quad_mode,
    output logic              overflow,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_ENT_W = ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_REG_WR = 3'd4,
        S_REG_RD = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    // ---------------- pin synchronizers and sck edge detect ----------------
    logic [SYNC_STAGES-1:0]      sck_sync_q, csn_sync_q;
    logic [SYNC_STAGES-1:0][3:0] sdi_sync_q;
    logic                        sck_prev_q;

    // csn sync resets to 0 so a reset in mid-frame is never mistaken for a
    // fresh frame start; armed_q only sets once csn is really seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q <= '0;
            csn_sync_q <= '0;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    logic       w_sck_s, w_csn_s, w_rise, w_fall;
    logic [3:0] w_sdi_s;
    assign w_sck_s = sck_sync_q[SYNC_STAGES-1];
    assign w_csn_s = csn_sync_q[SYNC_STAGES-1];
    assign w_sdi_s = sdi_sync_q[SYNC_STAGES-1];
    assign w_rise  = w_sck_s & ~sck_prev_q;
    assign w_fall  = ~w_sck_s & sck_prev_q;

    // ---------------- frame FSM ----------------
    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       tx_q, tx_d;
    logic [5:0]        rd_len_q, rd_len_d;
    logic [3:0]        sdo_q, sdo_d;
    logic              frame_quad_q, frame_quad_d;
    logic              armed_q, armed_d;
    logic              quad_mode_q, quad_mode_d;
    logic              overflow_q, overflow_d;
`ifdef SPI_WORD_CNT_EN
    logic [15:0]       wcnt_q, wcnt_d;
`endif

    logic [31:0] w_shift_in;
    logic [5:0]  w_cnt_inc;
    logic        w_push_req, w_reg_wr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        tx_d         = tx_q;
        rd_len_d     = rd_len_q;
        sdo_d        = sdo_q;
        frame_quad_d = frame_quad_q;
        armed_d      = armed_q;
        w_push_req   = 1'b0;
        w_reg_wr     = 1'b0;
        w_shift_in   = frame_quad_q ? {shift_q[27:0], w_sdi_s} : {shift_q[30:0], w_sdi_s[0]};
        w_cnt_inc    = cnt_q + (frame_quad_q ? 6'd4 : 6'd1);

        if (w_csn_s) begin
            // Deselect aborts whatever was in flight.
            state_d = S_IDLE;
            cnt_d   = '0;
            sdo_d   = '0;
            armed_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q) begin
                        state_d      = S_CMD;
                        cnt_d        = '0;
                        frame_quad_d = quad_mode_q;  // lane width fixed per frame
                    end
                end
                S_CMD: begin
                    if (w_rise) begin
                        shift_d = w_shift_in;
                        cnt_d   = w_cnt_inc;
                        if (w_cnt_inc == 6'd8) begin
                            cnt_d = '0;
                            case (w_shift_in[7:0])
                                8'h01: state_d = S_REG_WR;
                                8'h02: state_d = S_ADDR;
                                8'h05: begin
                                    state_d  = S_REG_RD;
                                    tx_d     = {6'b0, overflow_q, quad_mode_q, 8'h00};
                                    rd_len_d = 6'd8;
                                end
`ifdef SPI_WORD_CNT_EN
                                8'h07: begin
                                    state_d  = S_REG_RD;
                                    tx_d     = wcnt_q;
                                    rd_len_d = 6'd16;
                                end
`endif
                                default: state_d = S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rise) begin
                        shift_d = w_shift_in;
                        cnt_d   = w_cnt_inc;
                        if (w_cnt_inc == 6'd32) begin
                            cnt_d   = '0;
                            addr_d  = w_shift_in[ADDR_W-1:0];
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rise) begin
                        shift_d = w_shift_in;
                        cnt_d   = w_cnt_inc;
                        if (w_cnt_inc == 6'd32) begin
                            cnt_d      = '0;
                            w_push_req = 1'b1;
                            addr_d     = addr_q + ADDR_W'(4);  // advances even if dropped
                        end
                    end
                end
                S_REG_WR: begin
                    if (w_rise) begin
                        shift_d = w_shift_in;
                        cnt_d   = w_cnt_inc;
                        if (w_cnt_inc == 6'd8) begin
                            cnt_d    = '0;
                            w_reg_wr = 1'b1;
                            state_d  = S_IGNORE;
                        end
                    end
                end
                S_REG_RD: begin
                    // Drive on falling edges, count bits as the master samples them.
                    if (w_fall) begin
                        if (frame_quad_q) begin
                            sdo_d = tx_q[15:12];
                            tx_d  = {tx_q[11:0], 4'b0};
                        end else begin
                            sdo_d = {3'b0, tx_q[15]};
                            tx_d  = {tx_q[14:0], 1'b0};
                        end
                    end
                    if (w_rise) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == rd_len_q) begin
                            cnt_d   = '0;
                            sdo_d   = '0;
                            state_d = S_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write-request FIFO ----------------
    logic [c_ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W:0]   count_q, count_d;
    logic               w_full, w_pop, w_push, w_drop;

    assign w_full = (count_q == (c_PTR_W+1)'(FIFO_DEPTH));
    assign w_pop  = wr_valid & wr_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = w_push_req & (~w_full | w_pop);
    assign w_drop = w_push_req & w_full & ~w_pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        quad_mode_d = quad_mode_q;
        overflow_d  = overflow_q;
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
        if (w_drop) overflow_d = 1'b1;
        if (w_reg_wr) begin
            quad_mode_d = w_shift_in[0];
            if (w_shift_in[1]) overflow_d = 1'b0;
        end
`ifdef SPI_WORD_CNT_EN
        wcnt_d = wcnt_q;
        if (w_push && wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
        if (w_reg_wr && w_shift_in[2])    wcnt_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= {addr_q, w_shift_in[DATA_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            tx_q         <= '0;
            rd_len_q     <= '0;
            sdo_q        <= '0;
            frame_quad_q <= 1'b0;
            armed_q      <= 1'b0;
            quad_mode_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
`ifdef SPI_WORD_CNT_EN
            wcnt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            rd_len_q     <= rd_len_d;
            sdo_q        <= sdo_d;
            frame_quad_q <= frame_quad_d;
            armed_q      <= armed_d;
            quad_mode_q  <= quad_mode_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
`ifdef SPI_WORD_CNT_EN
            wcnt_q       <= wcnt_d;
`endif
        end
    end

    // ---------------- outputs ----------------
    assign wr_valid  = (count_q != '0);
    assign wr_addr   = wr_valid ? mem_q[rd_ptr_q][c_ENT_W-1:DATA_W] : '0;
    assign wr_data   = wr_valid ? mem_q[rd_ptr_q][DATA_W-1:0]       : '0;
    assign spi_sdo   = sdo_q;
    assign spi_oe    = (state_q == S_REG_RD) ? (frame_quad_q ? 4'hF : 4'h1) : 4'h0;
    assign quad_mode = quad_mode_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_wr_bridge.sv
// ============================================================================
// Module   : tb_spi_slave_wr_bridge
// Purpose  : Self-checking bench for spi_slave_wr_bridge. Drives the SPI
//            pins as a mode-0 master; expected write requests are queued
//            as frames are issued and a monitor compares every accepted
//            request against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_wr_bridge;

    localparam int HALF = 80;  // half sck period (8 clk)

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_csn = 1'b1;
    logic [3:0]  spi_sdi = 4'h0;
    logic [3:0]  spi_sdo, spi_oe;
    logic        quad_mode, overflow, wr_valid;
    logic        wr_ready = 1'b0;
    logic [31:0] wr_addr, wr_data;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [3:0]  oe_acc;
    bit          mq = 1'b0;  // master's idea of lane mode

    always #5 clk = ~clk;

    spi_slave_wr_bridge #(
        .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_oe(spi_oe),
        .quad_mode(quad_mode), .overflow(overflow),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: samples 3 ns after negedge, i.e. after stimulus settles and
    // before the posedge that performs the pop.
    always @(negedge clk) begin
        logic [63:0] e;
        #3;
        if (wr_valid && wr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_req actual=%0h_%0h required=none", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    failures++;
                    $display("FAIL wr_req actual=%0h_%0h required=%0h_%0h",
                             wr_addr, wr_data, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic xfer(input logic [31:0] val, input int nbits);
        int units;
        units = mq ? nbits / 4 : nbits;
        for (int i = units - 1; i >= 0; i--) begin
            if (mq) spi_sdi = val[i*4 +: 4];
            else    spi_sdi = {3'b0, val[i]};
            #HALF;
            oe_acc |= spi_oe;
            spi_sck = 1'b1;
            #HALF;
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        spi_csn = 1'b0;
        oe_acc  = 4'h0;
    endtask

    task automatic frame_end();
        #HALF;
        spi_csn = 1'b1;
        spi_sdi = 4'h0;
        #(4*HALF);
    endtask

    task automatic reg_read(input string name, input logic [7:0] req);
        logic [7:0] v;
        logic [3:0] oe_and, oe_or, oe_req;
        int         units;
        v = '0; oe_and = 4'hF; oe_or = 4'h0;
        oe_req = mq ? 4'hF : 4'h1;
        units  = mq ? 2 : 8;
        frame_begin();
        xfer(32'h05, 8);
        spi_sdi = 4'h0;
        for (int i = 0; i < units; i++) begin
            #HALF;
            v      = mq ? {v[3:0], spi_sdo} : {v[6:0], spi_sdo[0]};
            oe_and &= spi_oe;
            oe_or  |= spi_oe;
            spi_sck = 1'b1;
            #HALF;
            spi_sck = 1'b0;
        end
        frame_end();
        chk(name, v, req);
        chk({name, "_oe_and"}, oe_and, oe_req);
        chk({name, "_oe_or"}, oe_or, oe_req);
    endtask

    task automatic reg_write(input logic [7:0] val);
        frame_begin();
        xfer(32'h01, 8);
        xfer(val, 8);
        frame_end();
        mq = val[0];
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) #10;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        // ---- reset state ----
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_sdo", spi_sdo, 0);
        chk("rst_oe", spi_oe, 0);
        chk("rst_quad", quad_mode, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        #100;

        // ---- single-mode status read, then enable quad ----
        reg_read("rd_single", 8'h00);
        reg_write(8'h01);
        chk("quad_set", quad_mode, 1);
        reg_read("rd_quad", 8'h01);

        // ---- quad burst, two words, ready high ----
        wr_ready = 1'b1;
        exp_q.push_back({32'h0000_1000, 32'hDEAD_BEEF});
        exp_q.push_back({32'h0000_1004, 32'h1234_5678});
        frame_begin();
        xfer(32'h02, 8);
        xfer(32'h0000_1000, 32);
        xfer(32'hDEAD_BEEF, 32);
        xfer(32'h1234_5678, 32);
        frame_end();
        wait_drain("burst2_drain");
        chk("burst2_ovf", overflow, 0);

        // ---- overflow: 6 words into a 4-deep FIFO ----
        wr_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            exp_q.push_back({32'h2000 + 32'(4*k), 32'h1111_1111 * 32'(k+1)});
        frame_begin();
        xfer(32'h02, 8);
        xfer(32'h0000_2000, 32);
        for (int k = 0; k < 6; k++) xfer(32'h1111_1111 * 32'(k+1), 32);
        frame_end();
        chk("ovf_valid", wr_valid, 1);
        chk("ovf_head_addr", wr_addr, 32'h2000);
        chk("ovf_head_data", wr_data, 32'h1111_1111);
        chk("ovf_flag", overflow, 1);
        reg_read("rd_ovf", 8'h03);
        reg_write(8'h03);
        chk("ovf_cleared", overflow, 0);
        chk("ovf_quad_kept", quad_mode, 1);
        chk("ovf_head_held", wr_addr, 32'h2000);
        wr_ready = 1'b1;
        wait_drain("ovf_drain");
        chk("ovf_empty", wr_valid, 0);

        // ---- back to single; aborted word then full frame ----
        reg_write(8'h00);
        chk("quad_clr", quad_mode, 0);
        wr_ready = 1'b0;
        frame_begin();
        xfer(32'h02, 8);
        xfer(32'h0000_3000, 32);
        xfer(32'h000A_BCDE, 20);
        frame_end();
        chk("partial_no_valid", wr_valid, 0);
        wr_ready = 1'b1;
        exp_q.push_back({32'h0000_3000, 32'hCAFE_F00D});
        frame_begin();
        xfer(32'h02, 8);
        xfer(32'h0000_3000, 32);
        xfer(32'hCAFE_F00D, 32);
        frame_end();
        wait_drain("single_drain");

        // ---- unknown command ----
        frame_begin();
        xfer(32'hA5, 8);
        xfer(32'h5A5A_5A5A, 32);
        frame_end();
        chk("unk_oe", oe_acc, 0);
        chk("unk_valid", wr_valid, 0);
        chk("unk_quad", quad_mode, 0);

        // ---- reset in mid-burst ----
        reg_write(8'h01);
        chk("quad_set2", quad_mode, 1);
        wr_ready = 1'b0;
        frame_begin();
        xfer(32'h02, 8);
        xfer(32'h0000_4000, 32);
        xfer(32'hAAAA_0001, 32);
        xfer(32'hAAAA_0002, 32);
        xfer(32'h0000_0ABC, 12);
        chk("pre_rst_valid", wr_valid, 1);
        rst = 1'b1;
        #6;
        chk("rst_mid_valid", wr_valid, 0);
        chk("rst_mid_quad", quad_mode, 0);
        #4;
        rst = 1'b0;
        xfer(32'h000D_EF01, 20);
        xfer(32'hAAAA_0004, 32);
        frame_end();
        mq = 1'b0;
        chk("post_rst_valid", wr_valid, 0);
        chk("post_rst_ovf", overflow, 0);
        wr_ready = 1'b1;
        exp_q.push_back({32'h0000_5000, 32'h0BAD_F00D});
        frame_begin();
        xfer(32'h02, 8);
        xfer(32'h0000_5000, 32);
        xfer(32'h0BAD_F00D, 32);
        frame_end();
        wait_drain("post_rst_drain");

        #100;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
